// File: rtl/alu_sequencer.sv
// Command sequencer that drives an external combinational ALU through a 4-entry register file.
// Each command goes IDLE -> ISSUE -> CAPTURE -> RESPOND and is answered on a valid/ready response port.
module alu_sequencer #(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [3:0]   cmd_op,
    input  logic [1:0]   cmd_dst,
    input  logic [1:0]   cmd_srca,
    input  logic [1:0]   cmd_srcb,
    input  logic [n-1:0] cmd_imm,
    input  logic         cmd_fin,
    input  logic         cmd_use_c,
    output logic [n-1:0] alu_a,
    output logic [n-1:0] alu_b,
    output logic [3:0]   alu_ctrl,
    output logic         alu_flag_in,
    input  logic [n-1:0] alu_result,
    input  logic         alu_c,
    input  logic         alu_z,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [n-1:0] rsp_data,
    output logic         rsp_c,
    output logic         rsp_z,
    output logic         rsp_err,
    output logic         c_flag,
    output logic         z_flag
);

    localparam logic [3:0] OP_LOADI   = 4'hF;
    localparam logic [3:0] OP_ALU_MAX = 4'h9;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESPOND} state_t;

    state_t       state, state_next;
    logic [n-1:0] regs [4];
    logic [3:0]   op_q;
    logic [1:0]   dst_q;
    logic [n-1:0] imm_q;
    logic         accept;

    assign accept = cmd_valid && cmd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = ISSUE;
            ISSUE:   state_next = CAPTURE;
            CAPTURE: state_next = RESPOND;
            RESPOND: if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == IDLE);
        rsp_valid = (state == RESPOND);
    end

    // NOTE: the register file is reset along with the rest of the state, so an aborted write can never leave stale data behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) regs[i] <= '0;
            c_flag      <= 1'b0;
            z_flag      <= 1'b0;
            op_q        <= '0;
            dst_q       <= '0;
            imm_q       <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_ctrl    <= '0;
            alu_flag_in <= 1'b0;
            rsp_data    <= '0;
            rsp_c       <= 1'b0;
            rsp_z       <= 1'b0;
            rsp_err     <= 1'b0;
        end else if (accept) begin
            // Operands are snapshotted here, so dst may safely alias a source.
            op_q        <= cmd_op;
            dst_q       <= cmd_dst;
            imm_q       <= cmd_imm;
            alu_a       <= regs[cmd_srca];
            alu_b       <= regs[cmd_srcb];
            alu_ctrl    <= cmd_op;
            alu_flag_in <= cmd_use_c ? c_flag : cmd_fin;
        end else if (state == CAPTURE) begin
            if (op_q <= OP_ALU_MAX) begin
                regs[dst_q] <= alu_result;
                c_flag      <= alu_c;
                z_flag      <= alu_z;
                rsp_data    <= alu_result;
                rsp_c       <= alu_c;
                rsp_z       <= alu_z;
                rsp_err     <= 1'b0;
            end else if (op_q == OP_LOADI) begin
                regs[dst_q] <= imm_q;
                c_flag      <= 1'b0;
                z_flag      <= (imm_q == '0);
                rsp_data    <= imm_q;
                rsp_c       <= 1'b0;
                rsp_z       <= (imm_q == '0);
                rsp_err     <= 1'b0;
            end else begin
                rsp_data    <= '0;
                rsp_c       <= c_flag;
                rsp_z       <= z_flag;
                rsp_err     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: behavioural 4-bit ALU plus a register-file/flag scoreboard.
// Directed scenarios first, then randomized commands with random response back-pressure.
module tb_alu_sequencer;

    localparam int n = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [3:0]   cmd_op = '0;
    logic [1:0]   cmd_dst = '0, cmd_srca = '0, cmd_srcb = '0;
    logic [n-1:0] cmd_imm = '0;
    logic         cmd_fin = 1'b0, cmd_use_c = 1'b0;
    logic [n-1:0] alu_a, alu_b;
    logic [3:0]   alu_ctrl;
    logic         alu_flag_in;
    logic [n-1:0] alu_result;
    logic         alu_c, alu_z;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [n-1:0] rsp_data;
    logic         rsp_c, rsp_z, rsp_err;
    logic         c_flag, z_flag;

    int total = 0;
    int bad = 0;

    int          m_regs [4];
    bit          m_c, m_z;

    alu_sequencer #(.n(n)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_dst(cmd_dst), .cmd_srca(cmd_srca), .cmd_srcb(cmd_srcb),
        .cmd_imm(cmd_imm), .cmd_fin(cmd_fin), .cmd_use_c(cmd_use_c),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_flag_in(alu_flag_in),
        .alu_result(alu_result), .alu_c(alu_c), .alu_z(alu_z),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_c(rsp_c), .rsp_z(rsp_z), .rsp_err(rsp_err),
        .c_flag(c_flag), .z_flag(z_flag)
    );

    always #5 clk = ~clk;

    // ALU: 0 add, 1 adc, 2 sub, 3 sbb, 4 and, 5 or, 6 xor, 7 not, 8 shl, 9 shr; carry/borrow out in bit 4.
    function automatic logic [4:0] alu_ref(input int op, input int a, input int b, input int fi);
        int r, c;
        c = 0;
        case (op)
            0: begin r = a + b;      c = (r > 15); end
            1: begin r = a + b + fi; c = (r > 15); end
            2: begin r = a - b;      c = (a < b); end
            3: begin r = a - b - fi; c = (a < b + fi); end
            4: r = a & b;
            5: r = a | b;
            6: r = a ^ b;
            7: r = 15 - a;
            8: begin r = a * 2 + fi; c = (a >= 8); end
            9: begin r = a / 2 + fi * 8; c = a % 2; end
            default: r = 0;
        endcase
        r = ((r % 16) + 16) % 16;
        return {c[0], r[3:0]};
    endfunction

    logic [4:0] alu_out;
    assign alu_out    = alu_ref(int'(alu_ctrl), int'(alu_a), int'(alu_b), int'(alu_flag_in));
    assign alu_result = alu_out[3:0];
    assign alu_c      = alu_out[4];
    assign alu_z      = (alu_out[3:0] == 4'h0);

    task automatic check(input string tag, input int observed, input int expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = 0;
        m_c = 0;
        m_z = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_alu_a"}, int'(alu_a), 0);
        check({tag, "_alu_b"}, int'(alu_b), 0);
        check({tag, "_alu_ctrl"}, int'(alu_ctrl), 0);
        check({tag, "_alu_fi"}, int'(alu_flag_in), 0);
        check({tag, "_rsp_valid"}, int'(rsp_valid), 0);
        check({tag, "_rsp_data"}, int'(rsp_data), 0);
        check({tag, "_rsp_flags"}, int'({rsp_c, rsp_z, rsp_err}), 0);
        check({tag, "_flags"}, int'({c_flag, z_flag}), 0);
    endtask

    task automatic scramble_cmd();
        cmd_op    = 4'($urandom);
        cmd_dst   = 2'($urandom);
        cmd_srca  = 2'($urandom);
        cmd_srcb  = 2'($urandom);
        cmd_imm   = 4'($urandom);
        cmd_fin   = 1'($urandom);
        cmd_use_c = 1'($urandom);
    endtask

    // Drive one command, wait for acceptance, then step through the pipeline checking every stage.
    task automatic offer(input int op, input int dst, input int sa, input int sb,
                         input int imm, input int fin, input int usec);
        int w;
        @(negedge clk);
        cmd_op = 4'(op); cmd_dst = 2'(dst); cmd_srca = 2'(sa); cmd_srcb = 2'(sb);
        cmd_imm = 4'(imm); cmd_fin = 1'(fin); cmd_use_c = 1'(usec);
        cmd_valid = 1'b1;
        w = 0;
        while (!cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("cmd_ready_wait", int'(cmd_ready), 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        scramble_cmd();
    endtask

    task automatic do_cmd(input int op, input int dst, input int sa, input int sb,
                          input int imm, input int fin, input int usec, input int stall);
        int a, b, fi, exp_d, exp_c, exp_z, exp_e;
        logic [4:0] ar;
        a  = m_regs[sa];
        b  = m_regs[sb];
        fi = usec ? int'(m_c) : fin;
        if (op <= 9) begin
            ar = alu_ref(op, a, b, fi);
            exp_d = int'(ar[3:0]); exp_c = int'(ar[4]); exp_z = (exp_d == 0); exp_e = 0;
        end else if (op == 15) begin
            exp_d = imm; exp_c = 0; exp_z = (imm == 0); exp_e = 0;
        end else begin
            exp_d = 0; exp_c = int'(m_c); exp_z = int'(m_z); exp_e = 1;
        end

        offer(op, dst, sa, sb, imm, fin, usec);
        @(negedge clk);
        check("issue_alu_a", int'(alu_a), a);
        check("issue_alu_b", int'(alu_b), b);
        check("issue_alu_ctrl", int'(alu_ctrl), op);
        check("issue_alu_fi", int'(alu_flag_in), fi);
        check("issue_cmd_ready", int'(cmd_ready), 0);
        check("issue_rsp_valid", int'(rsp_valid), 0);
        @(negedge clk);
        check("capture_rsp_valid", int'(rsp_valid), 0);
        @(negedge clk);
        check("rsp_valid", int'(rsp_valid), 1);
        check("rsp_data", int'(rsp_data), exp_d);
        check("rsp_c", int'(rsp_c), exp_c);
        check("rsp_z", int'(rsp_z), exp_z);
        check("rsp_err", int'(rsp_err), exp_e);
        for (int s = 0; s < stall; s++) begin
            cmd_valid = 1'($urandom);
            @(negedge clk);
            check("stall_valid", int'(rsp_valid), 1);
            check("stall_data", int'({rsp_data, rsp_c, rsp_z, rsp_err}),
                  (exp_d << 3) | (exp_c << 2) | (exp_z << 1) | exp_e);
            check("stall_cmd_ready", int'(cmd_ready), 0);
            check("stall_alu_hold", int'({alu_ctrl, alu_a, alu_b}), (op << 8) | (a << 4) | b);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        if (op <= 9 || op == 15) begin
            m_regs[dst] = exp_d;
            m_c = exp_c[0];
            m_z = exp_z[0];
        end
        @(negedge clk);
        check("post_rsp_valid", int'(rsp_valid), 0);
        check("post_cmd_ready", int'(cmd_ready), 1);
        check("post_flags", int'({c_flag, z_flag}), int'({m_c, m_z}));
    endtask

    initial begin
        model_reset();
        #12;
        check_reset_outputs("reset");
        check("reset_cmd_ready", int'(cmd_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("release_cmd_ready", int'(cmd_ready), 1);

        // Load immediates, subtract, shift-left carry, then carry-in from the stored flag.
        do_cmd(15, 1, 0, 0, 9, 0, 0, 0);
        do_cmd(15, 2, 0, 0, 8, 0, 0, 0);
        do_cmd(2, 3, 1, 2, 0, 0, 0, 0);
        check("r3_is_1", m_regs[3], 1);
        do_cmd(8, 0, 1, 3, 0, 0, 0, 0);
        check("shl_carry_model", int'(m_c), 1);
        do_cmd(3, 0, 1, 2, 0, 0, 1, 0);
        do_cmd(15, 2, 0, 0, 0, 0, 0, 0);

        // Illegal opcode, then read registers back to confirm nothing moved.
        do_cmd(11, 1, 0, 0, 5, 0, 0, 1);
        do_cmd(5, 0, 1, 1, 0, 0, 0, 0);
        do_cmd(5, 0, 3, 3, 0, 0, 0, 5);

        // Reset during CAPTURE of a write to r3.
        do_cmd(15, 3, 0, 0, 7, 0, 0, 0);
        offer(0, 3, 3, 3, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1 check_reset_outputs("abort");
        check("abort_cmd_ready", int'(cmd_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1 check("abort_release_ready", int'(cmd_ready), 1);
        check("abort_release_valid", int'(rsp_valid), 0);
        do_cmd(5, 0, 3, 3, 0, 0, 0, 0);

        for (int i = 0; i < 60; i++) begin
            do_cmd(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 15)), int'($urandom_range(0, 1)),
                   int'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
